// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 subset core: opcodes, ALUOp encodings
// and the control bundle that travels down the pipeline.
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_R   = 7'b0110011;

  localparam logic [1:0] ALUOP_LDST = 2'b00;
  localparam logic [1:0] ALUOP_BEQ  = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;
  localparam logic [1:0] ALUOP_IMM  = 2'b11;

  // Decoder control bundle carried from ID into EX
  typedef struct packed {
    logic [1:0] ALUOp;
    logic       ALUSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       MemRead;
    logic       Mem2Reg;
    logic       Branch;
  } ctrl_t;

  // A bubble carries no side effects: no register, memory or branch action
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: flags when the load sitting in EX writes a
// register that the instruction in ID is about to read.
module hazard_detect (
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic       id_alu_src_i,
  input  logic       id_mem_write_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       raw_o
);

  logic useRs2;

  // rs1 always counts as read; rs2 only matters for R-type, beq and sw
  always_comb begin
    useRs2 = !id_alu_src_i | id_mem_write_i;
    raw_o  = ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) & id_valid_i &
             ((ex_rd_i == id_rs1_i) | (useRs2 & (ex_rd_i == id_rs2_i)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with built-in load-use stall, branch flush,
// global hold and a saturating count of inserted hazard bubbles.
import riscv_pkg::*;

module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             ALUSrc_i,
  input  logic             RegWrite_i,
  input  logic             MemWrite_i,
  input  logic             MemRead_i,
  input  logic             Mem2Reg_i,
  input  logic             Branch_i,
  input  logic [XLEN-1:0]  RS1data_i,
  input  logic [XLEN-1:0]  RS2data_i,
  input  logic [XLEN-1:0]  Imm_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [9:0]       funct_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic [4:0]       RDaddr_i,
  output logic [1:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic             RegWrite_o,
  output logic             MemWrite_o,
  output logic             MemRead_o,
  output logic             Mem2Reg_o,
  output logic             Branch_o,
  output logic [XLEN-1:0]  RS1data_o,
  output logic [XLEN-1:0]  RS2data_o,
  output logic [XLEN-1:0]  Imm_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [9:0]       funct_o,
  output logic [4:0]       RS1addr_o,
  output logic [4:0]       RS2addr_o,
  output logic [4:0]       RDaddr_o,
  output logic             valid_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             hazard_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  ctrl_t             ctrlIn;
  ctrl_t             ctrl_q, ctrl_d;
  logic [XLEN-1:0]   rs1data_q, rs1data_d;
  logic [XLEN-1:0]   rs2data_q, rs2data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [9:0]        funct_q, funct_d;
  logic [4:0]        rs1addr_q, rs1addr_d;
  logic [4:0]        rs2addr_q, rs2addr_d;
  logic [4:0]        rdaddr_q, rdaddr_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              raw;
  logic              hazard;

  assign ctrlIn = '{ALUOp: ALUOp_i, ALUSrc: ALUSrc_i, RegWrite: RegWrite_i,
                    MemWrite: MemWrite_i, MemRead: MemRead_i,
                    Mem2Reg: Mem2Reg_i, Branch: Branch_i};

  hazard_detect u_hazard_detect (
    .ex_valid_i     (valid_q),
    .ex_mem_read_i  (ctrl_q.MemRead),
    .ex_rd_i        (rdaddr_q),
    .id_valid_i     (valid_i),
    .id_alu_src_i   (ALUSrc_i),
    .id_mem_write_i (MemWrite_i),
    .id_rs1_i       (RS1addr_i),
    .id_rs2_i       (RS2addr_i),
    .raw_o          (raw)
  );

  // A taken branch squashes the stalled instruction anyway, so no stall then
  assign hazard      = raw & !flush_i;
  assign hazard_o    = hazard;
  assign PCWrite_o   = !hazard;
  assign IFIDWrite_o = !hazard;

  // Next state: hold keeps everything, flush/hazard load a bubble, else load ID
  always_comb begin
    ctrl_d    = ctrl_q;
    rs1data_d = rs1data_q;
    rs2data_d = rs2data_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    funct_d   = funct_q;
    rs1addr_d = rs1addr_q;
    rs2addr_d = rs2addr_q;
    rdaddr_d  = rdaddr_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    if (hold_i) begin
      cnt_d = cnt_q;
    end else if (flush_i || hazard) begin
      ctrl_d    = CTRL_BUBBLE;
      rs1data_d = '0;
      rs2data_d = '0;
      imm_d     = '0;
      pc_d      = '0;
      funct_d   = '0;
      rs1addr_d = '0;
      rs2addr_d = '0;
      rdaddr_d  = '0;
      valid_d   = 1'b0;
      if (!flush_i && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      ctrl_d    = ctrlIn;
      rs1data_d = RS1data_i;
      rs2data_d = RS2data_i;
      imm_d     = Imm_i;
      pc_d      = pc_i;
      funct_d   = funct_i;
      rs1addr_d = RS1addr_i;
      rs2addr_d = RS2addr_i;
      rdaddr_d  = RDaddr_i;
      valid_d   = valid_i;
    end
  end

  // Register bank with synchronous reset that overrides everything else
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q    <= CTRL_BUBBLE;
      rs1data_q <= '0;
      rs2data_q <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      funct_q   <= '0;
      rs1addr_q <= '0;
      rs2addr_q <= '0;
      rdaddr_q  <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs1data_q <= rs1data_d;
      rs2data_q <= rs2data_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      funct_q   <= funct_d;
      rs1addr_q <= rs1addr_d;
      rs2addr_q <= rs2addr_d;
      rdaddr_q  <= rdaddr_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ALUOp_o      = ctrl_q.ALUOp;
  assign ALUSrc_o     = ctrl_q.ALUSrc;
  assign RegWrite_o   = ctrl_q.RegWrite;
  assign MemWrite_o   = ctrl_q.MemWrite;
  assign MemRead_o    = ctrl_q.MemRead;
  assign Mem2Reg_o    = ctrl_q.Mem2Reg;
  assign Branch_o     = ctrl_q.Branch;
  assign RS1data_o    = rs1data_q;
  assign RS2data_o    = rs2data_q;
  assign Imm_o        = imm_q;
  assign pc_o         = pc_q;
  assign funct_o      = funct_q;
  assign RS1addr_o    = rs1addr_q;
  assign RS2addr_o    = rs2addr_q;
  assign RDaddr_o     = rdaddr_q;
  assign valid_o      = valid_q;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic,
// checked against a slot-level model of what EX should hold each cycle.
import riscv_pkg::*;

module tb_id_ex_stage;

  typedef struct packed {
    logic [1:0]  aluOp;
    logic        aluSrc;
    logic        regWrite;
    logic        memWrite;
    logic        memRead;
    logic        mem2Reg;
    logic        branch;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [9:0]  funct;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rd;
    logic        valid;
  } exSlot_t;

  logic    clk;
  logic    rst, hold, flush;
  exSlot_t inp;

  logic [1:0]  mALUOp, sALUOp;
  logic        mALUSrc, mRegWrite, mMemWrite, mMemRead, mMem2Reg, mBranch;
  logic        sALUSrc, sRegWrite, sMemWrite, sMemRead, sMem2Reg, sBranch;
  logic [31:0] mRS1data, mRS2data, mImm, mPc, sRS1data, sRS2data, sImm, sPc;
  logic [9:0]  mFunct, sFunct;
  logic [4:0]  mRS1addr, mRS2addr, mRDaddr, sRS1addr, sRS2addr, sRDaddr;
  logic        mValid, mPCWrite, mIFIDWrite, mHazard;
  logic        sValid, sPCWrite, sIFIDWrite, sHazard;
  logic [15:0] mCnt;
  logic [1:0]  sCnt;
  exSlot_t     obsMain, obsSat;

  exSlot_t ex;
  int      cntMain, cntSat;
  bit      expHaz;
  int      checks, failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush), .valid_i(inp.valid),
    .ALUOp_i(inp.aluOp), .ALUSrc_i(inp.aluSrc), .RegWrite_i(inp.regWrite),
    .MemWrite_i(inp.memWrite), .MemRead_i(inp.memRead), .Mem2Reg_i(inp.mem2Reg),
    .Branch_i(inp.branch), .RS1data_i(inp.rs1d), .RS2data_i(inp.rs2d),
    .Imm_i(inp.imm), .pc_i(inp.pc), .funct_i(inp.funct), .RS1addr_i(inp.rs1a),
    .RS2addr_i(inp.rs2a), .RDaddr_i(inp.rd),
    .ALUOp_o(mALUOp), .ALUSrc_o(mALUSrc), .RegWrite_o(mRegWrite),
    .MemWrite_o(mMemWrite), .MemRead_o(mMemRead), .Mem2Reg_o(mMem2Reg),
    .Branch_o(mBranch), .RS1data_o(mRS1data), .RS2data_o(mRS2data), .Imm_o(mImm),
    .pc_o(mPc), .funct_o(mFunct), .RS1addr_o(mRS1addr), .RS2addr_o(mRS2addr),
    .RDaddr_o(mRDaddr), .valid_o(mValid), .PCWrite_o(mPCWrite),
    .IFIDWrite_o(mIFIDWrite), .hazard_o(mHazard), .bubble_cnt_o(mCnt)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(2)) dutSat (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush), .valid_i(inp.valid),
    .ALUOp_i(inp.aluOp), .ALUSrc_i(inp.aluSrc), .RegWrite_i(inp.regWrite),
    .MemWrite_i(inp.memWrite), .MemRead_i(inp.memRead), .Mem2Reg_i(inp.mem2Reg),
    .Branch_i(inp.branch), .RS1data_i(inp.rs1d), .RS2data_i(inp.rs2d),
    .Imm_i(inp.imm), .pc_i(inp.pc), .funct_i(inp.funct), .RS1addr_i(inp.rs1a),
    .RS2addr_i(inp.rs2a), .RDaddr_i(inp.rd),
    .ALUOp_o(sALUOp), .ALUSrc_o(sALUSrc), .RegWrite_o(sRegWrite),
    .MemWrite_o(sMemWrite), .MemRead_o(sMemRead), .Mem2Reg_o(sMem2Reg),
    .Branch_o(sBranch), .RS1data_o(sRS1data), .RS2data_o(sRS2data), .Imm_o(sImm),
    .pc_o(sPc), .funct_o(sFunct), .RS1addr_o(sRS1addr), .RS2addr_o(sRS2addr),
    .RDaddr_o(sRDaddr), .valid_o(sValid), .PCWrite_o(sPCWrite),
    .IFIDWrite_o(sIFIDWrite), .hazard_o(sHazard), .bubble_cnt_o(sCnt)
  );

  assign obsMain = {mALUOp, mALUSrc, mRegWrite, mMemWrite, mMemRead, mMem2Reg, mBranch,
                    mRS1data, mRS2data, mImm, mPc, mFunct, mRS1addr, mRS2addr, mRDaddr, mValid};
  assign obsSat  = {sALUOp, sALUSrc, sRegWrite, sMemWrite, sMemRead, sMem2Reg, sBranch,
                    sRS1data, sRS2data, sImm, sPc, sFunct, sRS1addr, sRS2addr, sRDaddr, sValid};

  // Single comparison point: count it, report any difference
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every registered field of one EX slot against the model slot
  task automatic checkSlot(input string who, input exSlot_t o, input exSlot_t e);
    checkOutput({who, ".ctrl"}, {o.aluOp, o.aluSrc, o.regWrite, o.memWrite, o.memRead, o.mem2Reg, o.branch},
                {e.aluOp, e.aluSrc, e.regWrite, e.memWrite, e.memRead, e.mem2Reg, e.branch});
    checkOutput({who, ".rs1data"}, o.rs1d, e.rs1d);
    checkOutput({who, ".rs2data"}, o.rs2d, e.rs2d);
    checkOutput({who, ".imm"}, o.imm, e.imm);
    checkOutput({who, ".pc"}, o.pc, e.pc);
    checkOutput({who, ".funct_addr"}, {o.funct, o.rs1a, o.rs2a, o.rd}, {e.funct, e.rs1a, e.rs2a, e.rd});
    checkOutput({who, ".valid"}, o.valid, e.valid);
  endtask

  // Does the load currently in EX produce a register the ID instruction reads?
  function automatic bit loadUseModel();
    bit readsRs2;
    bit producesReg;
    readsRs2    = (inp.aluSrc == 1'b0) || (inp.memWrite == 1'b1);
    producesReg = ex.valid && ex.memRead && (ex.rd != 5'd0);
    return producesReg && inp.valid &&
           ((ex.rd == inp.rs1a) || (readsRs2 && (ex.rd == inp.rs2a)));
  endfunction

  // One clock: check stall outputs before the edge, advance model, check EX slot
  task automatic applyStimulus();
    #1;
    expHaz = loadUseModel() && !flush;
    if (!rst) begin
      checkOutput("hazard", mHazard, expHaz);
      checkOutput("PCWrite", mPCWrite, !expHaz);
      checkOutput("IFIDWrite", mIFIDWrite, !expHaz);
      checkOutput("sat.hazard", sHazard, expHaz);
      checkOutput("sat.PCWrite", sPCWrite, !expHaz);
      checkOutput("sat.IFIDWrite", sIFIDWrite, !expHaz);
    end
    @(posedge clk);
    if (rst) begin
      ex = '0; cntMain = 0; cntSat = 0;
    end else if (hold) begin
      ex = ex;
    end else if (flush) begin
      ex = '0;
    end else if (expHaz) begin
      ex = '0;
      if (cntMain < 65535) cntMain++;
      if (cntSat < 3) cntSat++;
    end else begin
      ex = inp;
    end
    #1;
    checkSlot("main", obsMain, ex);
    checkSlot("sat", obsSat, ex);
    checkOutput("bubble_cnt", mCnt, cntMain);
    checkOutput("sat.bubble_cnt", sCnt, cntSat);
    @(negedge clk);
  endtask

  function automatic exSlot_t instr(input logic [1:0] op, input bit src, input bit rw, input bit mw,
                                    input bit mr, input bit m2r, input bit br,
                                    input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                    input logic [31:0] imm);
    exSlot_t s;
    s.aluOp = op; s.aluSrc = src; s.regWrite = rw; s.memWrite = mw;
    s.memRead = mr; s.mem2Reg = m2r; s.branch = br;
    s.rs1d = $urandom; s.rs2d = $urandom; s.imm = imm; s.pc = $urandom;
    s.funct = 10'($urandom); s.rs1a = r1; s.rs2a = r2; s.rd = rd; s.valid = 1'b1;
    return s;
  endfunction

  function automatic exSlot_t randInstr();
    exSlot_t s;
    s = exSlot_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    s.rs1a    = 5'($urandom_range(0, 3));
    s.rs2a    = 5'($urandom_range(0, 3));
    s.rd      = 5'($urandom_range(0, 3));
    s.memRead = ($urandom_range(0, 1) == 1);
    s.valid   = ($urandom_range(0, 3) != 0);
    return s;
  endfunction

  function automatic exSlot_t lw(input logic [4:0] rd);
    return instr(ALUOP_LDST, 1, 1, 0, 1, 1, 0, 5'd1, 5'd0, rd, 32'd8);
  endfunction

  function automatic exSlot_t addR(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    return instr(ALUOP_R, 0, 1, 0, 0, 0, 0, r1, r2, rd, 32'd0);
  endfunction

  int satExp[5] = '{1, 2, 3, 3, 3};

  initial begin
    checks = 0; failures = 0;
    ex = '0; cntMain = 0; cntSat = 0;

    // Reset with every other input forced high
    inp = '1; rst = 1; hold = 1; flush = 1;
    applyStimulus();
    applyStimulus();
    rst = 0;
    #1;
    checkOutput("reset.PCWrite", mPCWrite, 1);
    checkOutput("reset.valid", mValid, 0);
    hold = 0; flush = 0;

    // addi x5,x1,7 passes straight through
    inp = instr(ALUOP_IMM, 1, 1, 0, 0, 0, 0, 5'd1, 5'd0, 5'd5, 32'd7);
    applyStimulus();
    checkOutput("addi.imm", mImm, 7);
    checkOutput("addi.rd", mRDaddr, 5);

    // lw x3 then add x4,x3,x2: one bubble, then add enters EX
    inp = lw(5'd3); applyStimulus();
    inp = addR(5'd4, 5'd3, 5'd2); applyStimulus();
    checkOutput("loaduse.bubbleValid", mValid, 0);
    checkOutput("loaduse.cnt", mCnt, 1);
    applyStimulus();
    checkOutput("loaduse.addRd", mRDaddr, 4);

    // lw x0 then use of x0: never stalls
    inp = lw(5'd0); applyStimulus();
    inp = addR(5'd4, 5'd0, 5'd0); applyStimulus();

    // lw x3 then addi with 3 only in the unused rs2 field: no stall
    inp = lw(5'd3); applyStimulus();
    inp = instr(ALUOP_IMM, 1, 1, 0, 0, 0, 0, 5'd1, 5'd3, 5'd6, 32'd3); applyStimulus();

    // lw x3 then sw x3,0(x1): store data depends on load, stall
    inp = lw(5'd3); applyStimulus();
    inp = instr(ALUOP_LDST, 1, 0, 1, 0, 0, 0, 5'd1, 5'd3, 5'd0, 32'd0); applyStimulus();
    applyStimulus();

    // Hazard coinciding with flush: flush wins
    inp = lw(5'd3); applyStimulus();
    inp = addR(5'd4, 5'd3, 5'd2); flush = 1; applyStimulus();
    flush = 0;

    // Hazard under hold: stall visible, state frozen, then resolves
    inp = lw(5'd3); applyStimulus();
    inp = addR(5'd4, 5'd3, 5'd2); hold = 1; applyStimulus();
    checkOutput("hold.memRead", mMemRead, 1);
    hold = 0; applyStimulus(); applyStimulus();

    // Random traffic with occasional hold, flush and reset
    for (int i = 0; i < 400; i++) begin
      inp   = randInstr();
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      applyStimulus();
    end
    rst = 0; hold = 0; flush = 0;

    // Saturation of the narrow counter across five load-use stalls
    rst = 1; applyStimulus(); rst = 0;
    for (int k = 0; k < 5; k++) begin
      inp = lw(5'd3); applyStimulus();
      inp = addR(5'd4, 5'd3, 5'd2); applyStimulus();
      checkOutput("sat.seq", sCnt, satExp[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
